// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH storage bank with one synchronous write port, two combinational
// read ports, optional write bypass, optional hardwired-zero entry 0 and a sequenced clear sweep.
module register_file #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int BYPASS = 0,
    parameter int ZERO_REG = 0,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr,
    output logic             busy
);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] mem [DEPTH];
    logic wr_ok, last;
    // an address is live when it maps to a real entry that is not the hardwired zero
    function automatic logic ok(input logic [AW-1:0] a);
        return 32'(a) < DEPTH && !(ZERO_REG != 0 && a == '0);
    endfunction
    assign last = cnt == AW'(DEPTH - 1);
    assign wr_ok = we && state == IDLE && !clr && ok(waddr);
    assign rdata_a = !ok(raddr_a) ? '0 : (BYPASS != 0 && wr_ok && raddr_a == waddr) ? wdata : mem[raddr_a];
    assign rdata_b = !ok(raddr_b) ? '0 : (BYPASS != 0 && wr_ok && raddr_b == waddr) ? wdata : mem[raddr_b];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
        end
    end
    always_comb begin
        state_n = state == IDLE ? (clr ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
        cnt_n = state == CLEAR && !last ? cnt + AW'(1) : '0;
    end
    always_comb busy = state == CLEAR;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: four register_file configurations share one stimulus stream; a scoreboard
// queue carries expected read data and busy per cycle, popped and compared on the falling edge.
module tb_register_file;
    logic clk = 0, rst_n = 0, we = 0, clr = 0;
    logic [2:0] waddr = 0, raddr_a = 0, raddr_b = 0;
    logic [15:0] wdata = 0;
    logic [15:0] rda [4];
    logic [15:0] rdb [4];
    logic bsy [4];
    int checks = 0, fails = 0;

    always #5 clk = ~clk;

    register_file #(.WIDTH(16), .DEPTH(8), .BYPASS(0), .ZERO_REG(0)) d0 (.clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda[0]), .rdata_b(rdb[0]), .clr(clr), .busy(bsy[0]));
    register_file #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_REG(0)) d1 (.clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda[1]), .rdata_b(rdb[1]), .clr(clr), .busy(bsy[1]));
    register_file #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_REG(1)) d2 (.clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda[2]), .rdata_b(rdb[2]), .clr(clr), .busy(bsy[2]));
    register_file #(.WIDTH(16), .DEPTH(5), .BYPASS(1), .ZERO_REG(0)) d3 (.clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda[3]), .rdata_b(rdb[3]), .clr(clr), .busy(bsy[3]));

    // reference model: per-configuration contents plus a "cycles of sweep done" count
    int dep [4] = '{8, 8, 8, 5};
    bit byp [4] = '{0, 1, 1, 1};
    bit zr [4] = '{0, 0, 1, 0};
    logic [15:0] m [4][8];
    bit sweeping [4];
    int swept [4];

    typedef struct packed {
        logic [3:0][15:0] ra;
        logic [3:0][15:0] rb;
        logic [3:0] b;
    } exp_t;
    exp_t q[$];

    function automatic bit accepted(int k);
        return we && !sweeping[k] && !clr && int'(waddr) < dep[k] && !(zr[k] && waddr == 0);
    endfunction

    function automatic logic [15:0] expect_rd(int k, logic [2:0] a);
        if (int'(a) >= dep[k] || (zr[k] && a == 0)) return 16'h0;
        if (byp[k] && accepted(k) && a == waddr) return wdata;
        return m[k][a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) m[k][i] = 16'h0;
            sweeping[k] = 0;
            swept[k] = 0;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 4; k++) begin
            if (sweeping[k]) begin
                m[k][swept[k]] = 16'h0;
                swept[k]++;
                if (swept[k] == dep[k]) sweeping[k] = 0;
            end else if (clr) begin
                sweeping[k] = 1;
                swept[k] = 0;
            end else if (accepted(k)) begin
                m[k][waddr] = wdata;
            end
        end
    endtask

    task automatic cyc(bit r, bit w, logic [2:0] wa, logic [15:0] wd, logic [2:0] a, logic [2:0] b, bit c);
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        rst_n = r; we = w; waddr = wa; wdata = wd; raddr_a = a; raddr_b = b; clr = c;
        if (!rst_n) model_reset();
        for (int k = 0; k < 4; k++) begin
            e.ra[k] = expect_rd(k, a);
            e.rb[k] = expect_rd(k, b);
            e.b[k] = sweeping[k];
        end
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            for (int k = 0; k < 4; k++) begin
                checks += 3;
                if (rda[k] !== e.ra[k]) begin
                    fails++;
                    $display("FAIL rdata_a d%0d t=%0t raddr=%0d got %h expected %h", k, $time, raddr_a, rda[k], e.ra[k]);
                end
                if (rdb[k] !== e.rb[k]) begin
                    fails++;
                    $display("FAIL rdata_b d%0d t=%0t raddr=%0d got %h expected %h", k, $time, raddr_b, rdb[k], e.rb[k]);
                end
                if (bsy[k] !== e.b[k]) begin
                    fails++;
                    $display("FAIL busy d%0d t=%0t got %b expected %b", k, $time, bsy[k], e.b[k]);
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) cyc(0, 0, 0, 0, 3, 5, 0);
        cyc(1, 0, 0, 0, 3, 5, 0);
        // basic write/read; writing with raddr equal to waddr exercises bypass vs old value
        cyc(1, 1, 3, 16'h0001, 3, 5, 0);
        cyc(1, 1, 5, 16'h000D, 3, 5, 0);
        cyc(1, 0, 3, 16'h0006, 3, 5, 0);
        cyc(1, 0, 3, 16'h0006, 3, 5, 0);
        cyc(1, 1, 2, 16'h1234, 0, 1, 0);
        cyc(1, 1, 2, 16'hBEEF, 2, 3, 0);
        cyc(1, 0, 2, 16'h0000, 2, 3, 0);
        cyc(1, 1, 0, 16'hFFFF, 0, 2, 0);
        cyc(1, 0, 0, 16'h0000, 0, 2, 0);
        // mid-run reset after writes
        cyc(0, 0, 0, 0, 3, 5, 0);
        cyc(1, 1, 6, 16'h5555, 6, 7, 0);
        cyc(1, 0, 0, 0, 6, 7, 0);
        // fill, then sweep with a dropped write to entry 7
        for (int i = 0; i < 8; i++) cyc(1, 1, 3'(i), 16'h00A0 + 16'(i), 3'(i), 3'(i), 0);
        cyc(1, 0, 0, 0, 0, 4, 1);
        for (int i = 0; i < 9; i++) cyc(1, i == 2, 7, 16'h7777, 3'(i % 8), 4, 0);
        cyc(1, 0, 0, 0, 7, 4, 0);
        // clr and we together: write dropped, sweep starts
        cyc(1, 1, 1, 16'h1111, 1, 2, 0);
        cyc(1, 1, 1, 16'h2222, 1, 2, 1);
        cyc(1, 0, 1, 0, 1, 2, 0);
        // reset two cycles into a sweep; nothing resumes
        repeat (7) cyc(1, 0, 0, 0, 1, 2, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 3'(i), 16'hC0 + 16'(i), 3'(i), 4, 0);
        cyc(1, 0, 0, 0, 0, 4, 1);
        cyc(1, 0, 0, 0, 0, 4, 0);
        cyc(0, 0, 0, 0, 3, 4, 0);
        cyc(1, 0, 0, 0, 3, 4, 0);
        cyc(1, 0, 0, 0, 4, 1, 0);
        // randomized traffic with occasional clears and resets
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(99) != 0, $urandom_range(2) != 0, 3'($urandom), 16'($urandom),
                3'($urandom), 3'($urandom), $urandom_range(24) == 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
